reg_bus_master: RTL and testbench

REG_BUS_MASTER -- requirements
Module: reg_bus_master

---
 rtl/reg_bus_master_pkg.sv | 14 +
 rtl/reg_bus_master.sv | 109 ++++++++++
 tb/tb_reg_bus_master.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_bus_master_pkg.sv
// Shared register-bus definitions: bus widths, default burst length width, master FSM states.
package reg_bus_master_pkg;

  localparam int REG_ADDR_SZ = 8;
  localparam int REG_DATA_SZ = 32;
  localparam int LEN_SZ_DFLT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } rb_state_e;

endpackage

// File: rtl/reg_bus_master.sv
// Burst register-bus master: one command in, cmd_len+1 single-cycle strobes out, one response per beat.
// Accept at edge N, strobe in N+1, rsp_vld in N+2; rsp_rdy low parks the FSM in RESP with outputs held.
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter int ADDR_INCR = 1,
  parameter int LEN_SZ    = LEN_SZ_DFLT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_vld,
  output logic                   cmd_rdy,
  input  logic                   cmd_wr,
  input  logic [REG_ADDR_SZ-1:0] cmd_addr,
  input  logic [LEN_SZ-1:0]      cmd_len,
  input  logic [REG_DATA_SZ-1:0] cmd_wdata,
  output logic                   rsp_vld,
  input  logic                   rsp_rdy,
  output logic [REG_DATA_SZ-1:0] rsp_data,
  output logic                   rsp_last,
  output logic                   rsp_wr,
  output logic                   reg_rd_en,
  output logic                   reg_wr_en,
  output logic [REG_ADDR_SZ-1:0] reg_addr,
  output logic [REG_DATA_SZ-1:0] reg_wr_data,
  input  logic [REG_DATA_SZ-1:0] reg_rd_data,
  output logic                   busy
);

  rb_state_e              state, state_nxt;
  logic                   wr_q;
  logic [REG_ADDR_SZ-1:0] addr_q;
  logic [LEN_SZ-1:0]      cnt_q;
  logic [REG_DATA_SZ-1:0] wdata_q;
  logic [REG_DATA_SZ-1:0] rsp_data_q;
  logic                   accept;
  logic                   beat_done;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_rdy     = 1'b0;
    accept      = 1'b0;
    beat_done   = 1'b0;
    rsp_vld     = 1'b0;
    rsp_last    = 1'b0;
    rsp_wr      = 1'b0;
    reg_rd_en   = 1'b0;
    reg_wr_en   = 1'b0;
    reg_addr    = '0;
    reg_wr_data = '0;
    case (state)
      IDLE: begin
        // rst_n gate keeps cmd_rdy low through the whole reset window
        cmd_rdy = rst_n;
        accept  = cmd_vld & rst_n;
        if (accept) state_nxt = ACCESS;
      end
      ACCESS: begin
        reg_rd_en   = ~wr_q;
        reg_wr_en   = wr_q;
        reg_addr    = addr_q;
        reg_wr_data = wr_q ? wdata_q : '0;
        state_nxt   = RESP;
      end
      RESP: begin
        rsp_vld  = 1'b1;
        rsp_last = (cnt_q == '0);
        rsp_wr   = wr_q;
        if (rsp_rdy) begin
          beat_done = (cnt_q != '0);
          state_nxt = (cnt_q == '0) ? IDLE : ACCESS;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q       <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        wr_q    <= cmd_wr;
        addr_q  <= cmd_addr;
        cnt_q   <= cmd_len;
        wdata_q <= cmd_wdata;
      end
      if (state == ACCESS) rsp_data_q <= wr_q ? '0 : reg_rd_data;
      // address wraps naturally at the register width
      if (beat_done) begin
        addr_q <= addr_q + REG_ADDR_SZ'(ADDR_INCR);
        cnt_q  <= cnt_q - 1'b1;
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master; slave returns {24'h0, addr} + 0x25 on reads.
module tb_reg_bus_master;
  import reg_bus_master_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic                   cmd_vld;
  logic                   cmd_rdy;
  logic                   cmd_wr;
  logic [REG_ADDR_SZ-1:0] cmd_addr;
  logic [3:0]             cmd_len;
  logic [REG_DATA_SZ-1:0] cmd_wdata;
  logic                   rsp_vld;
  logic                   rsp_rdy;
  logic [REG_DATA_SZ-1:0] rsp_data;
  logic                   rsp_last;
  logic                   rsp_wr;
  logic                   reg_rd_en;
  logic                   reg_wr_en;
  logic [REG_ADDR_SZ-1:0] reg_addr;
  logic [REG_DATA_SZ-1:0] reg_wr_data;
  logic [REG_DATA_SZ-1:0] reg_rd_data;
  logic                   busy;

  int n_vec;
  int n_err;

  reg_bus_master #(.ADDR_INCR(1), .LEN_SZ(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rsp_wr(rsp_wr),
    .reg_rd_en(reg_rd_en), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign reg_rd_data = reg_rd_en ? ({24'h0, reg_addr} + 32'h25) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [3:0] len,
                       input logic [31:0] wdata);
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_wdata = wdata;
    cmd_vld   = 1'b1;
    chk("issue_cmd_rdy", 32'(cmd_rdy), 32'd1);
    tick();
    cmd_vld = 1'b0;
  endtask

  logic [7:0]  wrap_addr [4];
  logic [31:0] wrap_dat  [4];

  initial begin
    n_vec = 0;
    n_err = 0;
    wrap_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    wrap_dat  = '{32'h123, 32'h124, 32'h25, 32'h26};
    rst_n = 1'b0; cmd_vld = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
    cmd_wdata = '0; rsp_rdy = 1'b1;

    // reset state
    tick(); tick();
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_strobes", {30'd0, reg_rd_en, reg_wr_en}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_cmd_rdy", 32'(cmd_rdy), 32'd1);

    // single read
    issue(1'b0, 8'h05, 4'd0, 32'h0);
    chk("rd_en", 32'(reg_rd_en), 32'd1);
    chk("rd_wr_en", 32'(reg_wr_en), 32'd0);
    chk("rd_addr", 32'(reg_addr), 32'h05);
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("rd_no_early_rsp", 32'(rsp_vld), 32'd0);
    tick();
    chk("rd_rsp_vld", 32'(rsp_vld), 32'd1);
    chk("rd_rsp_data", rsp_data, 32'h2A);
    chk("rd_rsp_last", 32'(rsp_last), 32'd1);
    chk("rd_rsp_wr", 32'(rsp_wr), 32'd0);
    chk("rd_strobe_off", {30'd0, reg_rd_en, reg_wr_en}, 32'd0);
    chk("rd_addr_off", 32'(reg_addr), 32'd0);
    tick();
    chk("rd_idle_busy", 32'(busy), 32'd0);
    chk("rd_idle_rsp", 32'(rsp_vld), 32'd0);

    // write burst of 3
    issue(1'b1, 8'h10, 4'd2, 32'hA5);
    for (int b = 0; b < 3; b++) begin
      chk("wb_wr_en", 32'(reg_wr_en), 32'd1);
      chk("wb_rd_en", 32'(reg_rd_en), 32'd0);
      chk("wb_addr", 32'(reg_addr), 32'h10 + 32'(b));
      chk("wb_wdata", reg_wr_data, 32'hA5);
      tick();
      chk("wb_rsp_vld", 32'(rsp_vld), 32'd1);
      chk("wb_rsp_data", rsp_data, 32'd0);
      chk("wb_rsp_wr", 32'(rsp_wr), 32'd1);
      chk("wb_rsp_last", 32'(rsp_last), (b == 2) ? 32'd1 : 32'd0);
      chk("wb_gap_strobe", 32'(reg_wr_en), 32'd0);
      chk("wb_gap_wdata", reg_wr_data, 32'd0);
      tick();
    end
    chk("wb_done_busy", 32'(busy), 32'd0);

    // backpressure on beat 1 of a 3-beat read
    issue(1'b0, 8'h20, 4'd2, 32'h0);
    tick();
    chk("bp_rsp0", rsp_data, 32'h45);
    tick();
    chk("bp_addr1", 32'(reg_addr), 32'h21);
    rsp_rdy = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_vld", 32'(rsp_vld), 32'd1);
      chk("bp_hold_data", rsp_data, 32'h46);
      chk("bp_hold_last", 32'(rsp_last), 32'd0);
      chk("bp_no_strobe", {30'd0, reg_rd_en, reg_wr_en}, 32'd0);
      chk("bp_cmd_rdy", 32'(cmd_rdy), 32'd0);
      if (i < 4) tick();
    end
    rsp_rdy = 1'b1;
    tick();
    chk("bp_resume_en", 32'(reg_rd_en), 32'd1);
    chk("bp_resume_addr", 32'(reg_addr), 32'h22);
    tick();
    chk("bp_last_data", rsp_data, 32'h47);
    chk("bp_last", 32'(rsp_last), 32'd1);
    tick();

    // address wrap
    issue(1'b0, 8'hFE, 4'd3, 32'h0);
    for (int b = 0; b < 4; b++) begin
      chk("wrap_en", 32'(reg_rd_en), 32'd1);
      chk("wrap_addr", 32'(reg_addr), 32'(wrap_addr[b]));
      tick();
      chk("wrap_data", rsp_data, wrap_dat[b]);
      chk("wrap_last", 32'(rsp_last), (b == 3) ? 32'd1 : 32'd0);
      tick();
    end

    // reset during beat 3 of a len-7 read
    issue(1'b0, 8'h40, 4'd7, 32'h0);
    tick(); tick(); tick(); tick();
    chk("mr_beat3_addr", 32'(reg_addr), 32'h42);
    rst_n = 1'b0;
    tick();
    chk("mr_strobe", {30'd0, reg_rd_en, reg_wr_en}, 32'd0);
    chk("mr_rsp_vld", 32'(rsp_vld), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_cmd_rdy", 32'(cmd_rdy), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr_rel_cmd_rdy", 32'(cmd_rdy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_stale", {30'd0, rsp_vld, busy}, 32'd0);
    end

    // second command held during a burst
    issue(1'b1, 8'h30, 4'd1, 32'h11);
    cmd_wr = 1'b0; cmd_addr = 8'h50; cmd_len = 4'd0; cmd_wdata = 32'hDEAD; cmd_vld = 1'b1;
    chk("q_a_addr0", 32'(reg_addr), 32'h30);
    chk("q_a_cmd_rdy", 32'(cmd_rdy), 32'd0);
    tick(); tick();
    chk("q_a_addr1", 32'(reg_addr), 32'h31);
    chk("q_a_wdata1", reg_wr_data, 32'h11);
    tick();
    chk("q_a_last", 32'(rsp_last), 32'd1);
    chk("q_a_cmd_rdy2", 32'(cmd_rdy), 32'd0);
    tick();
    chk("q_b_accept_rdy", 32'(cmd_rdy), 32'd1);
    chk("q_b_idle_busy", 32'(busy), 32'd0);
    tick();
    cmd_vld = 1'b0;
    chk("q_b_rd_en", 32'(reg_rd_en), 32'd1);
    chk("q_b_addr", 32'(reg_addr), 32'h50);
    tick();
    chk("q_b_data", rsp_data, 32'h75);
    chk("q_b_last", 32'(rsp_last), 32'd1);
    chk("q_b_wr", 32'(rsp_wr), 32'd0);
    tick();
    chk("q_b_done", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
